branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RV64 pipeline. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Lookup happens in IF from the current PC. Resolution comes back from the stage that evaluates the branch; the block raises a mispredict flag and supplies the redirect PC. It replaces the fixed not-taken and flush-on-branch behaviour of the current core, and adds saturating performance counters.

## Interface
- DATA_W, 64, PC/target width
- ENTRIES, 16, BTB entries; power of two, 2..256; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W+2 <= DATA_W
- CNT_W, 32, performance counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  global advance; low freezes all state
- flush  in  1  invalidate all BTB entries (after instruction-memory rewrite)
- lookup_pc  in  DATA_W  fetch PC
- pred_hit  out  1  valid BTB entry with matching tag
- pred_taken  out  1  hit and counter MSB = 1
- pred_target  out  DATA_W  stored target when pred_taken, else lookup_pc+4
- upd_valid  in  1  resolved control-flow instruction this cycle
- upd_pc  in  DATA_W  PC of resolved instruction
- upd_is_jump  in  1  1 = unconditional jump, 0 = conditional branch
- upd_taken  in  1  actual outcome (forced 1 by user for jumps)
- upd_target  in  DATA_W  actual taken target
- upd_pred_taken  in  1  prediction that was carried down the pipe
- upd_pred_target  in  DATA_W  predicted target that was carried down the pipe
- mispredict  out  1  resolved path differs from predicted path
- redirect_pc  out  DATA_W  correct next PC: upd_target if upd_taken, else upd_pc+4
- clr_stats  in  1  zero performance counters
- hit_count  out  CNT_W  lookups that hit (counted only while enable)
- mispredict_count  out  CNT_W  mispredicts counted

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Each entry holds valid, tag, target (DATA_W), ctr (2 bits).
- Lookup is combinational from lookup_pc and current entry state.
- mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)). It is combinational and asserted regardless of enable.
- redirect_pc is combinational; it is meaningful only when mispredict is 1.
- Update is applied on the clock edge when enable & upd_valid & !flush.
  - Hit on upd_pc, branch: ctr saturating increment if taken, decrement if not (00 floor, 11 ceiling). If taken, target <= upd_target.
  - Hit on upd_pc, jump: ctr <= 11 and target <= upd_target.
  - Miss with upd_taken = 1: allocate by overwriting the indexed entry. Set valid = 1, tag, target = upd_target, ctr = 11 for a jump, 10 for a branch.
  - Miss with upd_taken = 0: no change.
- flush & enable: all valid bits <= 0 next edge. Counters and targets are untouched. flush beats a simultaneous update.
- Performance counters:
  - hit_count increments when enable & pred_hit.
  - mispredict_count increments when enable & mispredict.
  - Both saturate at all-ones and never wrap.
  - clr_stats & enable zeroes both; clr_stats beats an increment in the same cycle.
- enable = 0: no BTB or counter change. Lookup and mispredict outputs stay live.

## Timing
- Reset: all valid bits = 0, all ctr = 01, all targets = 0, both counters = 0.
- After reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+4.
- Reset overrides enable, flush, upd_valid and clr_stats. Reset asserted mid-operation discards any update presented in that cycle.
- Lookup latency: 0 cycles (same-cycle combinational).
- Update latency: visible to lookup from the cycle after the update edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update entry (no write-through bypass).
- Aliasing: two PCs with the same index and different tags evict each other; the last allocation wins.

## Test plan
- Reset, then lookup_pc = 0x40 -> pred_hit = 0, pred_taken = 0, pred_target = 0x44, both counters = 0.
- Update pc = 0x40, branch, taken, target = 0x100, pred_taken = 0 -> mispredict = 1, redirect_pc = 0x100. Next cycle lookup 0x40 -> hit, taken, target = 0x100, ctr = 10.
- Three not-taken updates at 0x40 -> ctr goes 10→01→00→00; pred_taken = 0 from the first update onward. Each update with pred_taken = 1 flags mispredict with redirect_pc = 0x44.
- Jump at 0x80, target 0x200, plus lookup of 0x80 in the same cycle -> that lookup misses. Following cycle: hit, ctr = 11. Then flush together with an update -> all entries invalid and the update is dropped.
- ENTRIES = 16: allocate 0x40, then 0x440 (same index, different tag) -> 0x40 misses and 0x440 hits.
- CNT_W = 4: 20 hitting lookups -> hit_count saturates at 15. clr_stats together with a hit -> 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating direction counters,
// combinational lookup and mispredict detection, plus saturating performance counters.
module branch_predictor #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_lookup_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [DATA_W-1:0] o_pred_target,
  input  logic              i_upd_valid,
  input  logic [DATA_W-1:0] i_upd_pc,
  input  logic              i_upd_is_jump,
  input  logic              i_upd_taken,
  input  logic [DATA_W-1:0] i_upd_target,
  input  logic              i_upd_pred_taken,
  input  logic [DATA_W-1:0] i_upd_pred_target,
  output logic              o_mispredict,
  output logic [DATA_W-1:0] o_redirect_pc,
  input  logic              i_clr_stats,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

  localparam logic [1:0] CtrReset  = 2'b01;
  localparam logic [1:0] CtrAllocB = 2'b10;
  localparam logic [1:0] CtrMax    = 2'b11;

  // BTB storage
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [DATA_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [CNT_W-1:0]   r_hit_count;
  logic [CNT_W-1:0]   r_mispredict_count;

  // Lookup path
  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic               w_lk_taken;
  logic [DATA_W-1:0]  w_lk_seq_pc;

  // Update path
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_up_apply;
  logic [1:0]         w_up_ctr_old;
  logic [1:0]         w_up_ctr_inc;
  logic [1:0]         w_up_ctr_dec;

  logic               w_wr_en;
  logic [TAG_W-1:0]   w_wr_tag;
  logic [DATA_W-1:0]  w_wr_target;
  logic [1:0]         w_wr_ctr;

  logic               w_mispredict;
  logic               w_target_wrong;
  logic               w_hit_inc;
  logic               w_mis_inc;
  logic               w_clr;

  // ---------------------------------------------------------------------------
  // Lookup (same-cycle, reads pre-update state)
  // ---------------------------------------------------------------------------
  assign w_lk_idx    = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag    = i_lookup_pc[TAG_HI:TAG_LO];
  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign w_lk_seq_pc = i_lookup_pc + DATA_W'(4);

  always_comb begin
    o_pred_hit    = w_lk_hit;
    o_pred_taken  = w_lk_taken;
    o_pred_target = w_lk_taken ? r_target[w_lk_idx] : w_lk_seq_pc;
  end

  // ---------------------------------------------------------------------------
  // Resolution: mispredict and redirect are live regardless of enable
  // ---------------------------------------------------------------------------
  assign w_target_wrong = i_upd_taken && (i_upd_pred_target != i_upd_target);
  assign w_mispredict   = i_upd_valid &&
                          ((i_upd_pred_taken != i_upd_taken) || w_target_wrong);

  always_comb begin
    o_mispredict  = w_mispredict;
    o_redirect_pc = i_upd_taken ? i_upd_target : (i_upd_pc + DATA_W'(4));
  end

  // ---------------------------------------------------------------------------
  // BTB write decision
  // ---------------------------------------------------------------------------
  assign w_up_idx     = i_upd_pc[IDX_W+1:2];
  assign w_up_tag     = i_upd_pc[TAG_HI:TAG_LO];
  assign w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_apply   = i_enable && i_upd_valid && !i_flush;
  assign w_up_ctr_old = r_ctr[w_up_idx];
  assign w_up_ctr_inc = (w_up_ctr_old == CtrMax) ? CtrMax : (w_up_ctr_old + 2'd1);
  assign w_up_ctr_dec = (w_up_ctr_old == 2'b00) ? 2'b00 : (w_up_ctr_old - 2'd1);

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_tag    = w_up_tag;
    w_wr_target = r_target[w_up_idx];
    w_wr_ctr    = w_up_ctr_old;
    if (w_up_apply) begin
      if (w_up_hit) begin
        w_wr_en = 1'b1;
        if (i_upd_is_jump) begin
          w_wr_ctr    = CtrMax;
          w_wr_target = i_upd_target;
        end else if (i_upd_taken) begin
          w_wr_ctr    = w_up_ctr_inc;
          w_wr_target = i_upd_target;
        end else begin
          w_wr_ctr    = w_up_ctr_dec;
        end
      end else if (i_upd_taken) begin
        // Allocate over whatever occupies the indexed slot
        w_wr_en     = 1'b1;
        w_wr_target = i_upd_target;
        w_wr_ctr    = i_upd_is_jump ? CtrMax : CtrAllocB;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CtrReset;
      end
    end else if (i_enable && i_flush) begin
      r_valid <= '0;
    end else if (w_wr_en) begin
      r_valid[w_up_idx]  <= 1'b1;
      r_tag[w_up_idx]    <= w_wr_tag;
      r_target[w_up_idx] <= w_wr_target;
      r_ctr[w_up_idx]    <= w_wr_ctr;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  assign w_clr     = i_enable && i_clr_stats;
  assign w_hit_inc = i_enable && w_lk_hit && (r_hit_count != '1);
  assign w_mis_inc = i_enable && w_mispredict && (r_mispredict_count != '1);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_clr) begin
      r_hit_count        <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_hit_inc) r_hit_count <= r_hit_count + CNT_W'(1);
      if (w_mis_inc) r_mispredict_count <= r_mispredict_count + CNT_W'(1);
    end
  end

  assign o_hit_count        = r_hit_count;
  assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16, CNT_W=4 to reach saturation).
module tb_branch_predictor;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          flush;
  logic [DW-1:0] lookup_pc;
  logic          pred_hit;
  logic          pred_taken;
  logic [DW-1:0] pred_target;
  logic          upd_valid;
  logic [DW-1:0] upd_pc;
  logic          upd_is_jump;
  logic          upd_taken;
  logic [DW-1:0] upd_target;
  logic          upd_pred_taken;
  logic [DW-1:0] upd_pred_target;
  logic          mispredict;
  logic [DW-1:0] redirect_pc;
  logic          clr_stats;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] mispredict_count;

  branch_predictor #(
    .DATA_W (DW),
    .ENTRIES(16),
    .TAG_W  (8),
    .CNT_W  (CW)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_enable          (enable),
    .i_flush           (flush),
    .i_lookup_pc       (lookup_pc),
    .o_pred_hit        (pred_hit),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_is_jump     (upd_is_jump),
    .i_upd_taken       (upd_taken),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (mispredict),
    .o_redirect_pc     (redirect_pc),
    .i_clr_stats       (clr_stats),
    .o_hit_count       (hit_count),
    .o_mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] lk;
    logic          uv;
    logic [DW-1:0] upc;
    logic          jmp;
    logic          tk;
    logic [DW-1:0] tgt;
    logic          ptk;
    logic [DW-1:0] ptgt;
    logic          fl;
    logic          e_hit;
    logic          e_tk;
    logic [DW-1:0] e_tgt;
    logic          e_mis;
    logic [DW-1:0] e_rd;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int n_cmp;
  int n_fail;
  int m_hit;
  int m_mis;

  function automatic vec_t mk(input logic [DW-1:0] lk, input logic uv, input logic [DW-1:0] upc,
                              input logic jmp, input logic tk, input logic [DW-1:0] tgt,
                              input logic ptk, input logic [DW-1:0] ptgt, input logic fl,
                              input logic e_hit, input logic e_tk, input logic [DW-1:0] e_tgt,
                              input logic e_mis, input logic [DW-1:0] e_rd);
    vec_t v;
    v.lk = lk; v.uv = uv; v.upc = upc; v.jmp = jmp; v.tk = tk; v.tgt = tgt;
    v.ptk = ptk; v.ptgt = ptgt; v.fl = fl;
    v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_rd = e_rd;
    return v;
  endfunction

  // Lookup-only vector: no resolution, so redirect is 0+4
  function automatic vec_t lk_only(input logic [DW-1:0] lk, input logic e_hit, input logic e_tk,
                                   input logic [DW-1:0] e_tgt);
    return mk(lk, 0, 0, 0, 0, 0, 0, 0, 0, e_hit, e_tk, e_tgt, 0, 64'h4);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1; flush = 1'b0; clr_stats = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; m_hit = 0; m_mis = 0;
    idle_inputs();
    rst = 1'b1;

    // Index 0 holds 0x40 (tag 1), 0x80 (tag 2) and 0x440 (tag 0x11); 0x4 sits at index 1.
    vecs[0]  = lk_only(64'h40, 0, 0, 64'h44);
    vecs[1]  = mk(64'h40, 1, 64'h40, 0, 1, 64'h100, 0, 64'h44, 0, 0, 0, 64'h44, 1, 64'h100);
    vecs[2]  = lk_only(64'h40, 1, 1, 64'h100);
    vecs[3]  = mk(64'h40, 1, 64'h40, 0, 0, 0, 1, 64'h100, 0, 1, 1, 64'h100, 1, 64'h44);
    vecs[4]  = mk(64'h40, 1, 64'h40, 0, 0, 0, 1, 64'h100, 0, 1, 0, 64'h44, 1, 64'h44);
    vecs[5]  = mk(64'h40, 1, 64'h40, 0, 0, 0, 1, 64'h100, 0, 1, 0, 64'h44, 1, 64'h44);
    vecs[6]  = lk_only(64'h40, 1, 0, 64'h44);
    vecs[7]  = mk(64'h40, 1, 64'h40, 0, 1, 64'h100, 0, 64'h44, 0, 1, 0, 64'h44, 1, 64'h100);
    vecs[8]  = mk(64'h40, 1, 64'h40, 0, 1, 64'h120, 0, 64'h44, 0, 1, 0, 64'h44, 1, 64'h120);
    vecs[9]  = mk(64'h40, 1, 64'h40, 0, 1, 64'h120, 1, 64'h120, 0, 1, 1, 64'h120, 0, 64'h120);
    vecs[10] = mk(64'h40, 1, 64'h40, 0, 1, 64'h120, 1, 64'h124, 0, 1, 1, 64'h120, 1, 64'h120);
    vecs[11] = mk(64'h40, 1, 64'h40, 0, 0, 0, 1, 64'h120, 0, 1, 1, 64'h120, 1, 64'h44);
    vecs[12] = lk_only(64'h40, 1, 1, 64'h120);
    vecs[13] = mk(64'h80, 1, 64'h80, 1, 1, 64'h200, 0, 64'h84, 0, 0, 0, 64'h84, 1, 64'h200);
    vecs[14] = mk(64'h80, 1, 64'h80, 1, 1, 64'h300, 1, 64'h200, 0, 1, 1, 64'h200, 1, 64'h300);
    vecs[15] = lk_only(64'h40, 0, 0, 64'h44);
    vecs[16] = mk(64'h80, 1, 64'h4, 0, 0, 0, 0, 64'h8, 0, 1, 1, 64'h300, 0, 64'h8);
    vecs[17] = mk(64'h4, 1, 64'h4, 0, 1, 64'h500, 0, 64'h8, 1, 0, 0, 64'h8, 1, 64'h500);
    vecs[18] = lk_only(64'h80, 0, 0, 64'h84);
    vecs[19] = lk_only(64'h4, 0, 0, 64'h8);
    vecs[20] = mk(64'h40, 1, 64'h40, 0, 1, 64'h100, 0, 64'h44, 0, 0, 0, 64'h44, 1, 64'h100);
    vecs[21] = mk(64'h40, 1, 64'h440, 0, 1, 64'h600, 0, 64'h444, 0, 1, 1, 64'h100, 1, 64'h600);
    vecs[22] = lk_only(64'h40, 0, 0, 64'h44);
    vecs[23] = lk_only(64'h440, 1, 1, 64'h600);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      lookup_pc       = vecs[i].lk;
      upd_valid       = vecs[i].uv;
      upd_pc          = vecs[i].upc;
      upd_is_jump     = vecs[i].jmp;
      upd_taken       = vecs[i].tk;
      upd_target      = vecs[i].tgt;
      upd_pred_taken  = vecs[i].ptk;
      upd_pred_target = vecs[i].ptgt;
      flush           = vecs[i].fl;
      #1;
      check($sformatf("v%0d pred_hit", i), DW'(pred_hit), DW'(vecs[i].e_hit));
      check($sformatf("v%0d pred_taken", i), DW'(pred_taken), DW'(vecs[i].e_tk));
      check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_tgt);
      check($sformatf("v%0d mispredict", i), DW'(mispredict), DW'(vecs[i].e_mis));
      check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rd);
      check($sformatf("v%0d hit_count", i), DW'(hit_count), DW'(m_hit));
      check($sformatf("v%0d mispredict_count", i), DW'(mispredict_count), DW'(m_mis));
      tick();
      if (vecs[i].e_hit && m_hit < 15) m_hit++;
      if (vecs[i].e_mis && m_mis < 15) m_mis++;
    end
    idle_inputs();

    // enable low: mispredict stays live, but nothing (BTB, counters, flush) changes
    enable = 1'b0; flush = 1'b1; lookup_pc = 64'h440;
    upd_valid = 1'b1; upd_pc = 64'h440; upd_taken = 1'b0;
    upd_pred_taken = 1'b1; upd_pred_target = 64'h600;
    #1;
    check("frozen mispredict live", DW'(mispredict), 1);
    check("frozen lookup live", DW'(pred_hit), 1);
    tick();
    idle_inputs();
    lookup_pc = 64'h440;
    #1;
    check("frozen mis count", DW'(mispredict_count), DW'(m_mis));
    check("frozen hit kept", DW'(pred_hit), 1);
    check("frozen ctr kept", DW'(pred_taken), 1);

    // clr_stats beats a same-cycle hit increment
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; lookup_pc = 64'h0;
    #1;
    check("clr hit_count", DW'(hit_count), 0);
    check("clr mispredict_count", DW'(mispredict_count), 0);

    // 20 hitting lookups saturate a 4-bit counter at 15
    lookup_pc = 64'h440;
    for (int i = 0; i < 20; i++) tick();
    lookup_pc = 64'h0;
    #1;
    check("hit_count saturated", DW'(hit_count), 15);
    tick();
    check("hit_count held", DW'(hit_count), 15);

    // Reset with an allocating update in the same cycle discards it
    rst = 1'b1; upd_valid = 1'b1; upd_pc = 64'h4; upd_taken = 1'b1; upd_target = 64'h700;
    clr_stats = 1'b0; lookup_pc = 64'h4;
    tick();
    rst = 1'b0;
    idle_inputs();
    lookup_pc = 64'h4;
    #1;
    check("post-rst 0x4 miss", DW'(pred_hit), 0);
    check("post-rst 0x4 target", pred_target, 64'h8);
    check("post-rst hit_count", DW'(hit_count), 0);
    lookup_pc = 64'h440;
    #1;
    check("post-rst 0x440 miss", DW'(pred_hit), 0);
    check("post-rst 0x440 taken", DW'(pred_taken), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
